bram_ctrl: RTL and testbench

BRAM_CTRL -- requirements
Module: bram_ctrl

---
 rtl/bram_ctrl.sv | 90 +++++++++
 tb/tb_bram_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/bram_ctrl.sv
// Block-RAM controller: single-cycle writes, fixed-latency pipelined reads routed to DMA or CPU.
// Optional range checking is compiled in with `define BRAM_CTRL_RANGE_CHK_EN.
module bram_ctrl #(
  parameter int DELAYS = 10,
  parameter int DEPTH  = 7168
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        in_valid,
  input  logic        in_wr,
  input  logic [12:0] in_addr,
  input  logic [31:0] in_data,
  input  logic        in_reader_sel,
  output logic [31:0] dma_data_o,
  output logic        dma_valid_o,
  output logic [31:0] cpu_data_o,
  output logic        cpu_valid_o,
  output logic [4:0]  rd_inflight_o,
  output logic        err_o
);

`ifdef BRAM_CTRL_RANGE_CHK_EN
  localparam int MEM_WORDS = DEPTH;
  logic in_range;
  assign in_range = (int'({19'd0, in_addr}) < DEPTH);

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) err_o <= 1'b0;
    else          err_o <= in_valid & ~in_range;
  end
`else
  // DEPTH only matters when range checking is compiled in.
  localparam int MEM_WORDS = 8192 + 0 * DEPTH;
  logic in_range;
  assign in_range = 1'b1;
  assign err_o    = 1'b0;
`endif

  logic [31:0]       mem [MEM_WORDS];
  logic [31:0]       rd_word;
  logic              accept_rd;
  logic              accept_wr;
  logic [DELAYS-1:0] pv;
  logic [DELAYS-1:0] ps;
  logic [31:0]       pd [DELAYS];
  logic [4:0]        rd_cnt;
  logic              deliver;

  assign accept_rd     = in_valid & ~in_wr;
  assign accept_wr     = in_valid & in_wr & in_range;
  assign rd_word       = in_range ? mem[in_addr] : 32'h0000_0000;
  assign deliver       = pv[DELAYS-1];
  assign rd_inflight_o = rd_cnt;

  // Memory and read-data pipeline carry no reset; contents survive wb_rst_i.
  always_ff @(posedge wb_clk_i) begin
    if (accept_wr && !wb_rst_i) mem[in_addr] <= in_data;
    pd[0] <= rd_word;
    for (int i = 1; i < DELAYS; i++) pd[i] <= pd[i-1];
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      pv          <= '0;
      ps          <= '0;
      dma_valid_o <= 1'b0;
      cpu_valid_o <= 1'b0;
      dma_data_o  <= 32'h0000_0000;
      cpu_data_o  <= 32'h0000_0000;
      rd_cnt      <= 5'd0;
    end else begin
      pv[0] <= accept_rd;
      ps[0] <= in_reader_sel;
      for (int i = 1; i < DELAYS; i++) begin
        pv[i] <= pv[i-1];
        ps[i] <= ps[i-1];
      end
      dma_valid_o <= deliver & ~ps[DELAYS-1];
      cpu_valid_o <= deliver &  ps[DELAYS-1];
      if (deliver && !ps[DELAYS-1]) dma_data_o <= pd[DELAYS-1];
      if (deliver &&  ps[DELAYS-1]) cpu_data_o <= pd[DELAYS-1];
      case ({accept_rd, deliver})
        2'b10:   rd_cnt <= rd_cnt + 5'd1;
        2'b01:   rd_cnt <= rd_cnt - 5'd1;
        default: rd_cnt <= rd_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_bram_ctrl.sv
// Directed self-checking bench for bram_ctrl at default parameters (DELAYS=10).
module tb_bram_ctrl;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i;
  logic        in_valid;
  logic        in_wr;
  logic [12:0] in_addr;
  logic [31:0] in_data;
  logic        in_reader_sel;
  logic [31:0] dma_data_o;
  logic        dma_valid_o;
  logic [31:0] cpu_data_o;
  logic        cpu_valid_o;
  logic [4:0]  rd_inflight_o;
  logic        err_o;

  int total = 0;
  int bad   = 0;

  bram_ctrl dut (
    .wb_clk_i      (wb_clk_i),
    .wb_rst_i      (wb_rst_i),
    .in_valid      (in_valid),
    .in_wr         (in_wr),
    .in_addr       (in_addr),
    .in_data       (in_data),
    .in_reader_sel (in_reader_sel),
    .dma_data_o    (dma_data_o),
    .dma_valid_o   (dma_valid_o),
    .cpu_data_o    (cpu_data_o),
    .cpu_valid_o   (cpu_valid_o),
    .rd_inflight_o (rd_inflight_o),
    .err_o         (err_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  typedef struct {
    logic [12:0] addr;
    logic [31:0] wdata;
    bit          do_wr;
    bit          sel;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [6];

  task automatic tick();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic do_write(input logic [12:0] a, input logic [31:0] d);
    in_valid = 1'b1; in_wr = 1'b1; in_addr = a; in_data = d;
    tick();
    in_valid = 1'b0; in_wr = 1'b0;
  endtask

  task automatic issue_read(input logic [12:0] a, input bit sel);
    in_valid = 1'b1; in_wr = 1'b0; in_addr = a; in_reader_sel = sel;
    tick();
    in_valid = 1'b0;
  endtask

  // Waits for the pulse on the selected channel; lat counts edges still to come.
  task automatic wait_pulse(input bit sel, input logic [31:0] exp, input int lat, input string nm);
    int k = 0;
    bit seen = 0;
    bit wrong = 0;
    while (!seen && k < lat + 5) begin
      tick();
      k++;
      if (sel ? dma_valid_o : cpu_valid_o) wrong = 1;
      if (sel ? cpu_valid_o : dma_valid_o) seen = 1;
    end
    check({nm, "_lat"}, 32'(k), 32'(lat));
    check({nm, "_other"}, 32'(wrong), 32'd0);
    check({nm, "_data"}, sel ? cpu_data_o : dma_data_o, exp);
    tick();
    check({nm, "_width"}, 32'(sel ? cpu_valid_o : dma_valid_o), 32'd0);
    check({nm, "_hold"}, sel ? cpu_data_o : dma_data_o, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got [$];
    int   peak, first, last;
    bit   flag;

    vecs[0] = '{addr: 13'd5,    wdata: 32'h1234_5678, do_wr: 1, sel: 1, exp: 32'h1234_5678};
    vecs[1] = '{addr: 13'd7167, wdata: 32'h5A5A_A5A5, do_wr: 1, sel: 0, exp: 32'h5A5A_A5A5};
    vecs[2] = '{addr: 13'd100,  wdata: 32'hFEDC_BA98, do_wr: 1, sel: 0, exp: 32'hFEDC_BA98};
    vecs[3] = '{addr: 13'd5,    wdata: 32'h0,         do_wr: 0, sel: 0, exp: 32'h1234_5678};
    vecs[4] = '{addr: 13'd100,  wdata: 32'h0,         do_wr: 0, sel: 1, exp: 32'hFEDC_BA98};
    vecs[5] = '{addr: 13'd5,    wdata: 32'h0000_0001, do_wr: 1, sel: 1, exp: 32'h0000_0001};

    wb_rst_i = 1'b1; in_valid = 1'b0; in_wr = 1'b0; in_addr = '0; in_data = '0; in_reader_sel = 1'b0;
    tick(); tick(); tick();
    check("rst_dma_v", 32'(dma_valid_o), 32'd0);
    check("rst_cpu_v", 32'(cpu_valid_o), 32'd0);
    check("rst_dma_d", dma_data_o, 32'd0);
    check("rst_cpu_d", cpu_data_o, 32'd0);
    check("rst_inflight", 32'(rd_inflight_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    wb_rst_i = 1'b0;

    // Single write/read pairs with exact latency and routing.
    for (int v = 0; v < 6; v++) begin
      if (vecs[v].do_wr) do_write(vecs[v].addr, vecs[v].wdata);
      issue_read(vecs[v].addr, vecs[v].sel);
      check($sformatf("vec%0d_inflight", v), 32'(rd_inflight_o), 32'd1);
      wait_pulse(vecs[v].sel, vecs[v].exp, 10, $sformatf("vec%0d", v));
      check($sformatf("vec%0d_drain", v), 32'(rd_inflight_o), 32'd0);
    end

    // Ten back-to-back DMA reads.
    for (int i = 0; i < 10; i++) do_write(13'(i), 32'(i));
    peak = 0; first = -1; last = -1; flag = 0;
    for (int t = 0; t < 30; t++) begin
      if (t < 10) begin
        in_valid = 1'b1; in_wr = 1'b0; in_addr = 13'(t); in_reader_sel = 1'b0;
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (int'(rd_inflight_o) > peak) peak = int'(rd_inflight_o);
      if (dma_valid_o) begin
        got.push_back(dma_data_o);
        if (first < 0) first = t;
        last = t;
      end
      if (cpu_valid_o) flag = 1;
    end
    check("b2b_count", 32'(got.size()), 32'd10);
    check("b2b_first", 32'(first), 32'd10);
    check("b2b_last", 32'(last), 32'd19);
    for (int i = 0; i < got.size(); i++) check($sformatf("b2b_data%0d", i), got[i], 32'(i));
    check("b2b_peak", 32'(peak), 32'd10);
    check("b2b_drain", 32'(rd_inflight_o), 32'd0);
    check("b2b_cpu_quiet", 32'(flag), 32'd0);

    // Read-before-write on the following edge keeps the old word.
    do_write(13'd7, 32'hAAAA_AAAA);
    issue_read(13'd7, 1'b1);
    do_write(13'd7, 32'hBBBB_BBBB);
    wait_pulse(1'b1, 32'hAAAA_AAAA, 9, "raw_old");
    issue_read(13'd7, 1'b0);
    wait_pulse(1'b0, 32'hBBBB_BBBB, 10, "raw_new");

    // Alternating DMA/CPU reads.
    for (int i = 0; i < 4; i++) do_write(13'(20 + i), 32'hC0DE_0000 + 32'(i));
    flag = 0;
    for (int t = 0; t < 16; t++) begin
      if (t < 4) begin
        in_valid = 1'b1; in_wr = 1'b0; in_addr = 13'(20 + t); in_reader_sel = t[0];
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (dma_valid_o && cpu_valid_o) flag = 1;
      check($sformatf("alt_dma_v%0d", t), 32'(dma_valid_o), 32'(t == 10 || t == 12));
      check($sformatf("alt_cpu_v%0d", t), 32'(cpu_valid_o), 32'(t == 11 || t == 13));
      if (t >= 10) check($sformatf("alt_dma_d%0d", t), dma_data_o, t >= 12 ? 32'hC0DE_0002 : 32'hC0DE_0000);
      if (t >= 11) check($sformatf("alt_cpu_d%0d", t), cpu_data_o, t >= 13 ? 32'hC0DE_0003 : 32'hC0DE_0001);
    end
    check("alt_simul", 32'(flag), 32'd0);

    // Reset with four reads in flight; requests during reset are ignored.
    do_write(13'd30, 32'hCAFE_F00D);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_wr = 1'b0; in_addr = 13'(i); in_reader_sel = i[0];
      tick();
    end
    in_valid = 1'b0;
    check("rstmid_pre_inflight", 32'(rd_inflight_o), 32'd4);
    wb_rst_i = 1'b1;
    #1;
    check("rstmid_inflight", 32'(rd_inflight_o), 32'd0);
    check("rstmid_valids", {30'd0, dma_valid_o, cpu_valid_o}, 32'd0);
    in_valid = 1'b1; in_wr = 1'b1; in_addr = 13'd30; in_data = 32'hDEAD_DEAD;
    tick(); tick();
    check("rstmid_dma_d", dma_data_o, 32'd0);
    check("rstmid_cpu_d", cpu_data_o, 32'd0);
    in_valid = 1'b0; in_wr = 1'b0;
    wb_rst_i = 1'b0;
    flag = 0;
    for (int t = 0; t < 15; t++) begin
      tick();
      if (dma_valid_o || cpu_valid_o || rd_inflight_o != 5'd0) flag = 1;
    end
    check("rstmid_no_pulse", 32'(flag), 32'd0);
    issue_read(13'd30, 1'b1);
    wait_pulse(1'b1, 32'hCAFE_F00D, 10, "rstmid_keep");

    // Address 7168: out of range only when range checking is compiled in.
    do_write(13'd7168, 32'hFFFF_FFFF);
`ifdef BRAM_CTRL_RANGE_CHK_EN
    check("rng_err_wr", 32'(err_o), 32'd1);
    issue_read(13'd7168, 1'b0);
    check("rng_err_rd", 32'(err_o), 32'd1);
    wait_pulse(1'b0, 32'h0000_0000, 10, "rng_rd");
`else
    check("rng_err_wr", 32'(err_o), 32'd0);
    issue_read(13'd7168, 1'b0);
    check("rng_err_rd", 32'(err_o), 32'd0);
    wait_pulse(1'b0, 32'hFFFF_FFFF, 10, "rng_rd");
`endif
    check("rng_err_end", 32'(err_o), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
